banked_tcm: RTL and testbench
=============================

// Module: banked_tcm
// PURPOSE
//  Parametrised, single-clock, two-port tightly-coupled memory for the core.
//  Port A is the fetch side; port B is the load/store side.
//  Storage is NUM_BANKS word-interleaved single-port banks, so A and B proceed in parallel unless
//  they hit the same bank. Same-bank conflicts are arbitrated with a B starvation guard.
//  Replaces the fixed two-macro imem/dmem wrapper with req/gnt/rvalid handshakes.
// PARAMETERS
//  DATA_W        32  word width in bits; must be a multiple of 8
//  ADDR_W        14  word-address width per port
//  NUM_BANKS     4   interleave factor; power of 2, >=2
//  STARVE_LIMIT  3   consecutive B conflict losses before B wins; 0 = A always wins
// PORTS
//  clock     in   1         single clock, rising edge
//  reset     in   1         synchronous, active-high
//  a_req     in   1         A request valid
//  a_gnt     out  1         A request accepted this cycle (combinational)
//  a_addr    in   ADDR_W    A word address
//  a_we      in   1         A write (1) / read (0)
//  a_be      in   DATA_W/8  A byte enables; writes only
//  a_wdata   in   DATA_W    A write data
//  a_rvalid  out  1         A read data valid
//  a_rdata   out  DATA_W    A read data
//  b_*       --   --        identical set for port B
// BEHAVIOUR
//  - Address split:
//      bank = addr[BANK_W-1:0]
//      row  = addr[ADDR_W-1:BANK_W], with BANK_W = $clog2(NUM_BANKS)
//  - Handshake: a transfer happens in the cycle where req & gnt are both high.
//      Requester holds addr/we/be/wdata stable until gnt.
//  - gnt = req, unless both ports request the same bank and this port loses arbitration.
//  - Conflict winner:
//      B wins if STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT; otherwise A wins.
//  - starve_cnt (width $clog2(STARVE_LIMIT+1)):
//      +1 in each cycle B requests and loses;
//      cleared when B is granted or b_req is low;
//      saturates at STARVE_LIMIT.
//  - Reads:
//      rvalid goes high exactly 1 cycle after the granted read.
//      rdata is registered and holds its value until the next rvalid.
//      Back-to-back granted reads give rvalid high every cycle.
//  - Writes:
//      Granted byte lanes with be=1 update at the granting edge.
//      be=0 is granted and changes nothing. No rvalid is produced.
//      rdata is unchanged.
//  - Read after write, same port, same address, next cycle: returns the new data.
//  - A and B in different banks, same cycle: both granted. Each rvalid is independent, latency 1.
//  - Reset (any cycle, including mid-transfer):
//      - gnt forced 0 while reset is high.
//      - rvalid = 0 and rdata = 0 from the edge where reset is sampled.
//      - A read granted in the cycle before reset produces no rvalid.
//      - starve_cnt = 0.
//      - Array contents are not cleared.
//  - Unused rows (NUM_BANKS*2^ROW_W == 2^ADDR_W) do not exist; every address maps to storage.
// STRUCTURE
//  - tcm_pkg: BANK_W/ROW_W localparam functions, bank_of()/row_of() functions, and the
//    port-request struct typedef {we, be, addr, wdata}.
//  - Sub-module tcm_bank: single-port SRAM model with a macro-style active-low interface
//    (CEN, GWEN, per-byte WEN) and 1-cycle read latency. It is instantiated NUM_BANKS times,
//    so a compiled macro can be swapped in later.
//  - Top level holds conflict detection, the arbiter with starve_cnt, per-bank input muxes,
//    and the rvalid/bank-select return pipeline.
// TESTING
//  1 Reset: hold reset 2 cycles with a_req=b_req=1.
//      -> gnt=0; rvalid=0; rdata=0; starve_cnt=0.
//  2 Parallel: write A addr 0x0004 = 0xDEADBEEF and B addr 0x0005 = 0x12345678 in the same cycle;
//    then read both back.
//      -> both granted every cycle; each rvalid 1 cycle later with matching data.
//  3 Byte enables: write 0xFFFFFFFF to 0x0010; then write be=4'b0101, wdata=0x00000000; read.
//      -> 0xFF00FF00.
//  4 Conflict/starvation (STARVE_LIMIT=3): A and B read bank 0 continuously.
//      -> B granted on the 4th cycle only; A stalls that cycle; the pattern repeats every 4 cycles.
//  5 Mid-op reset: grant A read of 0x0004; assert reset on the next cycle.
//      -> no a_rvalid; after reset release, a read returns 0xDEADBEEF (contents kept).
//  6 Random: constrained-random req/addr/we/be on both ports vs. a scoreboard model, 10k cycles.
//      -> zero data mismatches; no lost or duplicated rvalid.

Source files
------------

// File: rtl/tcm_pkg.sv
// Shared types and address helpers for the banked tightly-coupled memory.
// Request fields are sized for the widest supported configuration; users slice down.
package tcm_pkg;

    localparam int TCM_MAX_DATA_W = 128;
    localparam int TCM_MAX_BE_W   = TCM_MAX_DATA_W / 8;
    localparam int TCM_MAX_ADDR_W = 32;

    function automatic int bank_w_f(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int row_w_f(input int addr_w, input int num_banks);
        return addr_w - $clog2(num_banks);
    endfunction

    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int num_banks);
        return addr & 32'(num_banks - 1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] addr, input int num_banks);
        return addr >> $clog2(num_banks);
    endfunction

    typedef struct packed {
        logic                      we;
        logic [TCM_MAX_BE_W-1:0]   be;
        logic [TCM_MAX_ADDR_W-1:0] addr;
        logic [TCM_MAX_DATA_W-1:0] wdata;
    } tcm_req_t;

endpackage

// File: rtl/tcm_bank.sv
// Single-port SRAM bank model with a macro-style active-low interface and
// one-cycle registered read data; kept pin-compatible with a compiled macro.
module tcm_bank #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 12
) (
    input  logic                  clk_i,
    input  logic                  cen_n_i,
    input  logic                  gwen_n_i,
    input  logic [DATA_W/8-1:0]   wen_n_i,
    input  logic [ROW_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     q_o
);

    logic [DATA_W-1:0] mem_q [2**ROW_W];
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!cen_n_i) begin
            if (!gwen_n_i) begin
                for (int j = 0; j < DATA_W / 8; j++) begin
                    if (!wen_n_i[j]) begin
                        mem_q[addr_i][8*j +: 8] <= wdata_i[8*j +: 8];
                    end
                end
            end else begin
                q_q <= mem_q[addr_i];
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/banked_tcm.sv
// Two-port word-interleaved TCM: port A fetch, port B load/store.
// Same-bank conflicts go to A unless B has lost STARVE_LIMIT times in a row.
module banked_tcm
    import tcm_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 14,
    parameter int NUM_BANKS    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                a_req_i,
    output logic                a_gnt_o,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic                a_we_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic                a_rvalid_o,
    output logic [DATA_W-1:0]   a_rdata_o,
    input  logic                b_req_i,
    output logic                b_gnt_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic                b_we_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    output logic                b_rvalid_o,
    output logic [DATA_W-1:0]   b_rdata_o
);

    localparam int BANK_W = bank_w_f(NUM_BANKS);
    localparam int ROW_W  = row_w_f(ADDR_W, NUM_BANKS);
    localparam int BE_W   = DATA_W / 8;
    localparam int SC_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    tcm_req_t          a_req_s, b_req_s;
    logic              unused_req_s;
    logic [BANK_W-1:0] bank_a_s, bank_b_s;
    logic              conflict_s, b_wins_s;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;

    logic [NUM_BANKS-1:0] a_sel_s, b_sel_s, cen_n_s, gwen_n_s;
    logic [BE_W-1:0]      wen_n_s  [NUM_BANKS];
    logic [ROW_W-1:0]     row_s    [NUM_BANKS];
    logic [DATA_W-1:0]    wdata_s  [NUM_BANKS];
    logic [DATA_W-1:0]    q_s      [NUM_BANKS];

    logic              a_rvalid_q, b_rvalid_q, a_live_s, b_live_s;
    logic [BANK_W-1:0] a_bank_q, b_bank_q;
    logic [DATA_W-1:0] a_hold_q, b_hold_q, a_rdata_d, b_rdata_d;

    assign a_req_s = '{we: a_we_i, be: TCM_MAX_BE_W'(a_be_i),
                       addr: TCM_MAX_ADDR_W'(a_addr_i), wdata: TCM_MAX_DATA_W'(a_wdata_i)};
    assign b_req_s = '{we: b_we_i, be: TCM_MAX_BE_W'(b_be_i),
                       addr: TCM_MAX_ADDR_W'(b_addr_i), wdata: TCM_MAX_DATA_W'(b_wdata_i)};
    assign unused_req_s = ^{a_req_s, b_req_s};

    // Conflict detection, arbitration and starvation counter next state.
    always_comb begin
        bank_a_s   = BANK_W'(bank_of(a_req_s.addr, NUM_BANKS));
        bank_b_s   = BANK_W'(bank_of(b_req_s.addr, NUM_BANKS));
        conflict_s = a_req_i & b_req_i & (bank_a_s == bank_b_s);
        b_wins_s   = (STARVE_LIMIT != 0) && (starve_cnt_q == SC_W'(STARVE_LIMIT));
        a_gnt_o    = a_req_i & ~rst_i & ~(conflict_s & b_wins_s);
        b_gnt_o    = b_req_i & ~rst_i & ~(conflict_s & ~b_wins_s);
        if (!b_req_i || b_gnt_o) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Per-bank input steering; at most one port selects a given bank.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            a_sel_s[i] = a_gnt_o & (bank_a_s == BANK_W'(i));
            b_sel_s[i] = b_gnt_o & (bank_b_s == BANK_W'(i));
            cen_n_s[i] = ~(a_sel_s[i] | b_sel_s[i]);
            if (a_sel_s[i]) begin
                gwen_n_s[i] = ~a_req_s.we;
                wen_n_s[i]  = ~a_req_s.be[BE_W-1:0];
                row_s[i]    = ROW_W'(row_of(a_req_s.addr, NUM_BANKS));
                wdata_s[i]  = a_req_s.wdata[DATA_W-1:0];
            end else begin
                gwen_n_s[i] = ~b_req_s.we;
                wen_n_s[i]  = ~b_req_s.be[BE_W-1:0];
                row_s[i]    = ROW_W'(row_of(b_req_s.addr, NUM_BANKS));
                wdata_s[i]  = b_req_s.wdata[DATA_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        tcm_bank #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
            .clk_i    (clk_i),
            .cen_n_i  (cen_n_s[g]),
            .gwen_n_i (gwen_n_s[g]),
            .wen_n_i  (wen_n_s[g]),
            .addr_i   (row_s[g]),
            .wdata_i  (wdata_s[g]),
            .q_o      (q_s[g])
        );
    end

    // Return path: a read in flight is dropped if reset lands on its data cycle.
    always_comb begin
        a_live_s  = a_rvalid_q & ~rst_i;
        b_live_s  = b_rvalid_q & ~rst_i;
        a_rdata_d = a_live_s ? q_s[a_bank_q] : a_hold_q;
        b_rdata_d = b_live_s ? q_s[b_bank_q] : b_hold_q;
    end

    assign a_rvalid_o = a_live_s;
    assign b_rvalid_o = b_live_s;
    assign a_rdata_o  = a_rdata_d;
    assign b_rdata_o  = b_rdata_d;

    // Return pipeline and arbiter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_bank_q     <= '0;
            b_bank_q     <= '0;
            a_hold_q     <= '0;
            b_hold_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            a_rvalid_q   <= a_gnt_o & ~a_we_i;
            b_rvalid_q   <= b_gnt_o & ~b_we_i;
            a_bank_q     <= bank_a_s;
            b_bank_q     <= bank_b_s;
            a_hold_q     <= a_rdata_d;
            b_hold_q     <= b_rdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_banked_tcm.sv
// Directed vector table, multi-cycle corner sequences and a random
// scoreboard run for banked_tcm with the default configuration.
module tb_banked_tcm;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_gnt, a_we, a_rvalid;
    logic [13:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;
    logic        b_req, b_gnt, b_we, b_rvalid;
    logic [13:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata, b_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    banked_tcm dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_gnt_o(a_gnt), .a_addr_i(a_addr), .a_we_i(a_we),
        .a_be_i(a_be), .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_gnt_o(b_gnt), .b_addr_i(b_addr), .b_we_i(b_we),
        .b_be_i(b_be), .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata)
    );

    typedef struct {
        logic ar, aw; logic [13:0] aa; logic [3:0] abe; logic [31:0] ad;
        logic br, bw; logic [13:0] ba; logic [3:0] bbe; logic [31:0] bd;
        logic eag, ebg, earv, ebrv; logic [31:0] ead, ebd;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic ar, aw, input logic [13:0] aa, input logic [3:0] abe,
                                input logic [31:0] ad, input logic br, bw, input logic [13:0] ba,
                                input logic [3:0] bbe, input logic [31:0] bd,
                                input logic eag, ebg, earv, input logic [31:0] ead,
                                input logic ebrv, input logic [31:0] ebd);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.abe = abe; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bbe = bbe; v.bd = bd;
        v.eag = eag; v.ebg = ebg; v.earv = earv; v.ead = ead; v.ebrv = ebrv; v.ebd = ebd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = 14'h0; a_be = 4'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 14'h0; b_be = 4'h0; b_wdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // random-phase model state
    logic [31:0] mem_m [16];
    logic [31:0] kn_m  [16];
    int          sc;
    logic        pa, pb, a_hold, b_hold, conf, bw_m, eag, ebg;
    logic [31:0] ea, eb, ma, mb;

    initial begin
        idle();
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_addr = 14'h4; b_addr = 14'h4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        next_cycle();
        rst = 1'b0;
        idle();

        // parallel writes/reads, byte enables, conflict with A priority, be=0 write
        vecs[0] = mk(1,1,14'h4,4'hF,32'hDEADBEEF, 1,1,14'h5,4'hF,32'h12345678, 1,1, 0,32'h0, 0,32'h0);
        vecs[1] = mk(1,0,14'h4,4'h0,32'h0, 1,0,14'h5,4'h0,32'h0, 1,1, 0,32'h0, 0,32'h0);
        vecs[2] = mk(1,1,14'h10,4'hF,32'hFFFFFFFF, 0,0,14'h0,4'h0,32'h0, 1,0, 1,32'hDEADBEEF, 1,32'h12345678);
        vecs[3] = mk(1,1,14'h10,4'h5,32'h0, 1,0,14'h4,4'h0,32'h0, 1,0, 0,32'hDEADBEEF, 0,32'h12345678);
        vecs[4] = mk(1,0,14'h10,4'h0,32'h0, 1,0,14'h4,4'h0,32'h0, 1,0, 0,32'hDEADBEEF, 0,32'h12345678);
        vecs[5] = mk(0,0,14'h0,4'h0,32'h0, 1,0,14'h4,4'h0,32'h0, 0,1, 1,32'hFF00FF00, 0,32'h12345678);
        vecs[6] = mk(1,0,14'h10,4'h0,32'h0, 1,1,14'h5,4'h0,32'h0, 1,1, 0,32'hFF00FF00, 1,32'hDEADBEEF);
        vecs[7] = mk(0,0,14'h0,4'h0,32'h0, 1,0,14'h5,4'h0,32'h0, 0,1, 1,32'hFF00FF00, 0,32'hDEADBEEF);
        vecs[8] = mk(0,0,14'h0,4'h0,32'h0, 0,0,14'h0,4'h0,32'h0, 0,0, 0,32'hFF00FF00, 1,32'h12345678);

        for (int i = 0; i < 9; i++) begin
            a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa; a_be = vecs[i].abe; a_wdata = vecs[i].ad;
            b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_be = vecs[i].bbe; b_wdata = vecs[i].bd;
            @(negedge clk);
            chk($sformatf("v%0d_a_gnt", i), {31'd0, a_gnt}, {31'd0, vecs[i].eag});
            chk($sformatf("v%0d_b_gnt", i), {31'd0, b_gnt}, {31'd0, vecs[i].ebg});
            chk($sformatf("v%0d_a_rvalid", i), {31'd0, a_rvalid}, {31'd0, vecs[i].earv});
            chk($sformatf("v%0d_b_rvalid", i), {31'd0, b_rvalid}, {31'd0, vecs[i].ebrv});
            chk($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].ead);
            chk($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].ebd);
            next_cycle();
        end

        // starvation guard: B wins every 4th cycle of a continuous bank-0 conflict
        a_req = 1'b1; a_addr = 14'h0; b_req = 1'b1; b_addr = 14'h4;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("starve%0d_a_gnt", k), {31'd0, a_gnt}, (k % 4 == 3) ? 32'd0 : 32'd1);
            chk($sformatf("starve%0d_b_gnt", k), {31'd0, b_gnt}, (k % 4 == 3) ? 32'd1 : 32'd0);
            next_cycle();
        end
        idle();
        next_cycle();

        // reset lands on the data cycle of a granted read
        a_req = 1'b1; a_addr = 14'h4;
        @(negedge clk);
        chk("midrst_a_gnt", {31'd0, a_gnt}, 32'd1);
        next_cycle();
        rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        chk("midrst_a_rvalid0", {31'd0, a_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("midrst_a_rvalid1", {31'd0, a_rvalid}, 32'd0);
        chk("midrst_a_rdata", a_rdata, 32'd0);
        next_cycle();
        rst = 1'b0;
        a_req = 1'b1; a_addr = 14'h4;
        @(negedge clk);
        chk("postrst_a_gnt", {31'd0, a_gnt}, 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("postrst_a_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("postrst_a_rdata", a_rdata, 32'hDEADBEEF);
        next_cycle();

        // random traffic on 16 words against a scoreboard
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = 32'h0;
            kn_m[i]  = 32'h0;
        end
        sc = 0; pa = 1'b0; pb = 1'b0; a_hold = 1'b0; b_hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!a_hold) begin
                a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
                a_addr = 14'($urandom_range(0, 15)); a_be = 4'($urandom); a_wdata = $urandom;
            end
            if (!b_hold) begin
                b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
                b_addr = 14'($urandom_range(0, 15)); b_be = 4'($urandom); b_wdata = $urandom;
            end
            @(negedge clk);
            chk("rnd_a_rvalid", {31'd0, a_rvalid}, {31'd0, pa});
            chk("rnd_b_rvalid", {31'd0, b_rvalid}, {31'd0, pb});
            if (pa) chk("rnd_a_rdata", a_rdata & ma, ea & ma);
            if (pb) chk("rnd_b_rdata", b_rdata & mb, eb & mb);
            conf = a_req && b_req && (a_addr[1:0] == b_addr[1:0]);
            bw_m = conf && (sc == 3);
            eag  = a_req && !(conf && bw_m);
            ebg  = b_req && !(conf && !bw_m);
            chk("rnd_a_gnt", {31'd0, a_gnt}, {31'd0, eag});
            chk("rnd_b_gnt", {31'd0, b_gnt}, {31'd0, ebg});
            if (!b_req || ebg) sc = 0;
            else if (sc < 3) sc = sc + 1;
            pa = eag && !a_we;
            pb = ebg && !b_we;
            ea = mem_m[a_addr[3:0]]; ma = kn_m[a_addr[3:0]];
            eb = mem_m[b_addr[3:0]]; mb = kn_m[b_addr[3:0]];
            for (int j = 0; j < 4; j++) begin
                if (eag && a_we && a_be[j]) begin
                    mem_m[a_addr[3:0]][8*j +: 8] = a_wdata[8*j +: 8];
                    kn_m[a_addr[3:0]][8*j +: 8]  = 8'hFF;
                end
                if (ebg && b_we && b_be[j]) begin
                    mem_m[b_addr[3:0]][8*j +: 8] = b_wdata[8*j +: 8];
                    kn_m[b_addr[3:0]][8*j +: 8]  = 8'hFF;
                end
            end
            a_hold = a_req && !eag;
            b_hold = b_req && !ebg;
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("drain_a_rvalid", {31'd0, a_rvalid}, {31'd0, pa});
        chk("drain_b_rvalid", {31'd0, b_rvalid}, {31'd0, pb});
        if (pa) chk("drain_a_rdata", a_rdata & ma, ea & ma);
        if (pb) chk("drain_b_rdata", b_rdata & mb, eb & mb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
